mc_responder: RTL and testbench

MC_RESPONDER -- requirements
Module: mc_responder

---
 rtl/mc_responder.sv | 178 +++++++++++++++++
 tb/tb_mc_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_responder.sv
// Memory-controller responder: 64-bit word memory answering load/store requests in order.
// Latency: a load response appears on mc_rsp_push one cycle after acceptance when nothing is queued ahead of it.
// Backpressure: mc_rsp_stall holds responses in a small FIFO; mc_req_stall rises one entry short of full.

module mc_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign rd_dat = store[rd_ptr];

    // Entry storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            store[wr_ptr] <= wr_dat;
        end
    end

    // Pointer and occupancy bookkeeping; the caller never overflows or underflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_rdy) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_vld) - CNT_W'(rd_rdy);
        end
    end
endmodule

module mc_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mc_req_ld,
    input  logic        mc_req_st,
    input  logic [47:0] mc_req_vadr,
    input  logic [63:0] mc_req_wrd_rdctl,
    output logic        mc_req_stall,
    output logic        mc_rsp_push,
    output logic [31:0] mc_rsp_rdctl,
    output logic [63:0] mc_rsp_data,
    input  logic        mc_rsp_stall,
    output logic        err,
    output logic [31:0] ld_count,
    output logic [31:0] st_count
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int WORDS = 2 ** ADDR_WIDTH;

    typedef struct packed {
        logic [31:0] rdctl;
        logic [63:0] data;
    } rsp_t;

    logic [63:0]           mem [WORDS];
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_nonempty;
    rsp_t                  fifo_head;
    rsp_t                  new_rsp;
    logic                  accept;
    logic                  addr_ok;
    logic [47:0]           vadr_hi;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  st_do;
    logic                  st_write;
    logic                  ld_do;
    logic                  pop;
    logic                  bypass;
    logic                  enq;
    logic                  proto_err;

    // Stall comes only from registered occupancy, leaving one slot for a load racing the stall.
    assign mc_req_stall  = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
    assign accept        = (mc_req_ld | mc_req_st) & ~mc_req_stall;

    assign vadr_hi       = mc_req_vadr >> (ADDR_WIDTH + 3);
    assign addr_ok       = (vadr_hi == '0) && (mc_req_vadr[2:0] == 3'b000);
    assign idx           = mc_req_vadr[ADDR_WIDTH+2:3];

    // A combined ld+st request executes as a store; the load half is discarded.
    assign st_do         = accept & mc_req_st;
    assign st_write      = st_do & addr_ok;
    assign ld_do         = accept & mc_req_ld & ~mc_req_st;
    assign proto_err     = accept & ((mc_req_ld & mc_req_st) | ~addr_ok);

    assign fifo_nonempty = (fifo_count != '0);
    assign pop           = ~mc_rsp_stall & fifo_nonempty;
    assign bypass        = ~mc_rsp_stall & ~fifo_nonempty & ld_do;
    assign enq           = ld_do & ~bypass;

    // Form the load response from the pre-edge memory contents; bad addresses return zero.
    always_comb begin
        new_rsp       = '0;
        new_rsp.rdctl = mc_req_wrd_rdctl[31:0];
        new_rsp.data  = addr_ok ? mem[idx] : 64'd0;
    end

    // Word memory is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (st_write) begin
            mem[idx] <= mc_req_wrd_rdctl;
        end
    end

    mc_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (enq),
        .wr_dat (new_rsp),
        .rd_rdy (pop),
        .rd_dat (fifo_head),
        .count  (fifo_count)
    );

    // Output stage: FIFO head has priority over a fresh load, which then queues behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_rsp_push  <= 1'b0;
            mc_rsp_rdctl <= '0;
            mc_rsp_data  <= '0;
        end else if (pop) begin
            mc_rsp_push  <= 1'b1;
            mc_rsp_rdctl <= fifo_head.rdctl;
            mc_rsp_data  <= fifo_head.data;
        end else if (bypass) begin
            mc_rsp_push  <= 1'b1;
            mc_rsp_rdctl <= new_rsp.rdctl;
            mc_rsp_data  <= new_rsp.data;
        end else begin
            mc_rsp_push  <= 1'b0;
        end
    end

    // Sticky error flag and accepted-request counters, which count bad addresses too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err      <= 1'b0;
            ld_count <= '0;
            st_count <= '0;
        end else begin
            if (proto_err) begin
                err <= 1'b1;
            end
            if (ld_do) begin
                ld_count <= ld_count + 32'd1;
            end
            if (st_do) begin
                st_count <= st_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_mc_responder.sv
module tb_mc_responder;
    localparam int AW = 8;
    localparam int D  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mc_req_ld = 1'b0;
    logic        mc_req_st = 1'b0;
    logic [47:0] mc_req_vadr = '0;
    logic [63:0] mc_req_wrd_rdctl = '0;
    logic        mc_req_stall;
    logic        mc_rsp_push;
    logic [31:0] mc_rsp_rdctl;
    logic [63:0] mc_rsp_data;
    logic        mc_rsp_stall = 1'b0;
    logic        err;
    logic [31:0] ld_count;
    logic [31:0] st_count;

    mc_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(D)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .mc_req_ld        (mc_req_ld),
        .mc_req_st        (mc_req_st),
        .mc_req_vadr      (mc_req_vadr),
        .mc_req_wrd_rdctl (mc_req_wrd_rdctl),
        .mc_req_stall     (mc_req_stall),
        .mc_rsp_push      (mc_rsp_push),
        .mc_rsp_rdctl     (mc_rsp_rdctl),
        .mc_rsp_data      (mc_rsp_data),
        .mc_rsp_stall     (mc_rsp_stall),
        .err              (err),
        .ld_count         (ld_count),
        .st_count         (st_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdctl;
        logic [63:0] data;
    } exp_t;

    // Reference model: ordered list of owed responses, word array, counters.
    exp_t        exp_q[$];
    logic [63:0] mem_m [2**AW];
    int          pending = 0;       // responses accepted but not yet presented
    logic [31:0] ldc_m = 0;
    logic [31:0] stc_m = 0;
    logic        err_m = 1'b0;
    logic        exp_push = 1'b0;   // whether a push is owed after the coming edge
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, req);
        end
    endtask

    // Monitor: after each edge, compare push timing and pop the scoreboard on every push.
    always @(posedge clk) begin
        exp_t e;
        #1;
        check("push_timing", mc_rsp_push, exp_push);
        if (mc_rsp_push) begin
            if (exp_q.size() == 0) begin
                check("unexpected_push", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdctl", mc_rsp_rdctl, e.rdctl);
                check("rsp_data", mc_rsp_data, e.data);
            end
        end
        check("fifo_bound", (u_dut.u_fifo.count <= D), 1'b1);
    end

    // One cycle of stimulus, called at a falling edge; the model predicts the next rising edge.
    task automatic tick(input logic ld, input logic st, input logic [47:0] va,
                        input logic [63:0] wd, input logic rs);
        logic          acc;
        logic          ok;
        logic [AW-1:0] idx;
        logic          newr;
        exp_t          r;
        check("req_stall", mc_req_stall, (pending >= D - 1));
        check("err", err, err_m);
        check("ld_count", ld_count, ldc_m);
        check("st_count", st_count, stc_m);

        acc  = (ld || st) && !(pending >= D - 1);
        ok   = ((va >> (AW + 3)) == 48'd0) && (va[2:0] == 3'd0);
        idx  = va[AW+2:3];
        newr = 1'b0;
        if (acc && st) begin
            stc_m++;
            if (ok) mem_m[idx] = wd;
        end
        if (acc && ld && !st) begin
            ldc_m++;
            r.rdctl = wd[31:0];
            r.data  = ok ? mem_m[idx] : 64'd0;
            exp_q.push_back(r);
            newr = 1'b1;
        end
        if (acc && ((ld && st) || !ok)) err_m = 1'b1;

        // Owed responses drain one per unstalled cycle, oldest first.
        if (!rs && (pending > 0 || newr)) begin
            exp_push = 1'b1;
            pending  = pending + int'(newr) - 1;
        end else begin
            exp_push = 1'b0;
            pending  = pending + int'(newr);
        end

        mc_req_ld        = ld;
        mc_req_st        = st;
        mc_req_vadr      = va;
        mc_req_wrd_rdctl = wd;
        mc_rsp_stall     = rs;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        mc_req_ld        = 1'b0;
        mc_req_st        = 1'b0;
        mc_rsp_stall     = 1'b0;
        exp_q.delete();
        pending  = 0;
        ldc_m    = 0;
        stc_m    = 0;
        err_m    = 1'b0;
        exp_push = 1'b0;
        #1;
        check("rst_push", mc_rsp_push, 1'b0);
        check("rst_rdctl", mc_rsp_rdctl, 32'd0);
        check("rst_data", mc_rsp_data, 64'd0);
        check("rst_stall", mc_req_stall, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ld_count", ld_count, 32'd0);
        check("rst_st_count", st_count, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] saved;
        logic [47:0] va;
        int          p;
        @(negedge clk);
        do_reset();

        // Combined ld+st from a clean state: store wins, load dropped, error raised.
        tick(1'b1, 1'b1, 48'h8, 64'hAB, 1'b0);
        check("t034_st_count", st_count, 32'd1);
        check("t034_ld_count", ld_count, 32'd0);
        check("t034_err", err, 1'b1);
        check("t034_push", mc_rsp_push, 1'b0);
        tick(1'b1, 1'b0, 48'h8, 64'h34, 1'b0);
        check("t034_word1", mc_rsp_data, 64'hAB);

        do_reset();
        for (int i = 0; i < 2**AW; i++) begin
            tick(1'b0, 1'b1, 48'(i * 8), {$urandom, $urandom}, 1'b0);
        end

        // Store then immediate load of the same word.
        tick(1'b0, 1'b1, 48'h10, 64'h1122334455667788, 1'b0);
        tick(1'b1, 1'b0, 48'h10, 64'h5, 1'b0);
        check("t032_push", mc_rsp_push, 1'b1);
        check("t032_rdctl", mc_rsp_rdctl, 32'h5);
        check("t032_data", mc_rsp_data, 64'h1122334455667788);
        tick(1'b0, 1'b0, 48'h0, 64'h0, 1'b0);
        check("t032_single_push", mc_rsp_push, 1'b0);

        // Response backpressure fills the FIFO to the stall threshold.
        for (int t = 1; t <= 5; t++) begin
            tick(1'b1, 1'b0, 48'(t * 8), 64'(t), 1'b1);
        end
        check("t033_stall", mc_req_stall, 1'b1);
        check("t033_no_push", mc_rsp_push, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick(1'b0, 1'b0, 48'h0, 64'h0, 1'b0);
            check("t033_drain_push", mc_rsp_push, 1'b1);
            check("t033_drain_tag", mc_rsp_rdctl, 32'(k));
        end
        tick(1'b0, 1'b0, 48'h0, 64'h0, 1'b0);
        check("t033_drained", mc_rsp_push, 1'b0);

        // Out-of-range load answers with zero; misaligned store leaves memory alone.
        tick(1'b1, 1'b0, 48'h1_0000_0000, 64'h9, 1'b0);
        check("t035_push", mc_rsp_push, 1'b1);
        check("t035_rdctl", mc_rsp_rdctl, 32'h9);
        check("t035_data", mc_rsp_data, 64'h0);
        check("t035_err", err, 1'b1);
        saved = mem_m[0];
        tick(1'b0, 1'b1, 48'h3, 64'hDEAD_BEEF_0000_0003, 1'b0);
        tick(1'b1, 1'b0, 48'h0, 64'h35, 1'b0);
        check("t035_unchanged", mc_rsp_data, saved);
        check("t035_err_sticky", err, 1'b1);

        // Reset with two queued responses: they vanish, memory survives.
        tick(1'b1, 1'b0, 48'h18, 64'h61, 1'b1);
        tick(1'b1, 1'b0, 48'h20, 64'h62, 1'b1);
        check("t036_queued", u_dut.u_fifo.count, 64'd2);
        do_reset();
        tick(1'b0, 1'b0, 48'h0, 64'h0, 1'b0);
        check("t036_no_push", mc_rsp_push, 1'b0);
        tick(1'b1, 1'b0, 48'h10, 64'h63, 1'b0);
        check("t036_preserved", mc_rsp_data, 64'h1122334455667788);

        // Random mix with random response backpressure.
        for (int c = 0; c < 10000; c++) begin
            p  = int'($urandom_range(0, 99));
            va = 48'($urandom_range(0, 2**AW - 1)) << 3;
            if (p < 4) va = {16'($urandom), 32'($urandom)};
            else if (p < 9) va = va | 48'($urandom_range(1, 7));
            p = int'($urandom_range(0, 99));
            tick(p < 45 || (p >= 80 && p < 84), p >= 45 && p < 84, va,
                 {$urandom, $urandom}, $urandom_range(0, 99) < 40);
        end

        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 48'h0, 64'h0, 1'b0);
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
